// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and ASCII helpers for the hex LCD driver.
// LCD_PREFIX_EN adds a "0x" prefix, making each row 10 characters long.
package lcd_pkg;

   typedef enum logic [2:0] {
      PWRUP, INIT, ADDR1, ROW1, ADDR2, ROW2, DONE
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE, PH_SETUP, PH_EN, PH_WAIT
   } phase_t;

   localparam logic [7:0] CMD_FUNC  = 8'h38;
   localparam logic [7:0] CMD_DISP  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_ENTRY = 8'h06;
   localparam logic [7:0] CMD_ROW1  = 8'h80;
   localparam logic [7:0] CMD_ROW2  = 8'hC0;

   localparam logic [7:0] ASC_DIGIT = 8'h30;
   localparam logic [7:0] ASC_ALPHA = 8'h41;
   localparam logic [7:0] ASC_X     = 8'h78;

`ifdef LCD_PREFIX_EN
   localparam int ROW_LEN = 10;
`else
   localparam int ROW_LEN = 8;
`endif

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10)
         return ASC_DIGIT + {4'd0, n};
      else
         return ASC_ALPHA + {4'd0, n} - 8'd10;
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] i);
      case (i)
         2'd0:    return CMD_FUNC;
         2'd1:    return CMD_DISP;
         2'd2:    return CMD_CLEAR;
         default: return CMD_ENTRY;
      endcase
   endfunction

endpackage

// File: rtl/lcd_hex_driver_strobe.sv
// One HD44780 write: setup clock, EN pulse, then the settle wait.
// A new start is accepted while idle or on the final wait clock.
module lcd_strobe
   import lcd_pkg::*;
#(
   parameter int EN_CYCLES    = 12,
   parameter int CMD_CYCLES   = 2500,
   parameter int CLEAR_CYCLES = 82000,
   parameter int TW           = 17
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   input  logic       rs,
   input  logic       long_wait,
   output logic       busy,
   output logic       done,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_en
);

   localparam logic [TW-1:0] EN_LAST  = TW'(EN_CYCLES - 1);
   localparam logic [TW-1:0] CMD_LAST = TW'(CMD_CYCLES - 1);
   localparam logic [TW-1:0] CLR_LAST = TW'(CLEAR_CYCLES - 1);

   phase_t        phase;
   logic [TW-1:0] timer;
   logic          long_q;
   logic          accept;

   assign busy   = (phase != PH_IDLE);
   assign done   = (phase == PH_WAIT) && (timer == '0);
   assign accept = start && (!busy || done);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         phase    <= PH_IDLE;
         timer    <= '0;
         long_q   <= 1'b0;
         lcd_data <= 8'h00;
         lcd_rs   <= 1'b0;
         lcd_en   <= 1'b0;
      end else begin
         unique case (phase)
            PH_SETUP: begin
               phase  <= PH_EN;
               lcd_en <= 1'b1;
               timer  <= EN_LAST;
            end
            PH_EN: begin
               if (timer == '0) begin
                  lcd_en <= 1'b0;
                  phase  <= PH_WAIT;
                  timer  <= long_q ? CLR_LAST : CMD_LAST;
               end else begin
                  timer <= timer - TW'(1);
               end
            end
            PH_WAIT: begin
               if (timer == '0)
                  phase <= PH_IDLE;
               else
                  timer <= timer - TW'(1);
            end
            default: ;
         endcase
         // Back-to-back: the next setup clock follows the last wait clock
         if (accept) begin
            phase    <= PH_SETUP;
            lcd_data <= data;
            lcd_rs   <= rs;
            long_q   <= long_wait;
         end
      end
   end

endmodule

// File: rtl/lcd_hex_driver.sv
// HD44780 driver showing two 32-bit words in hex, refreshed continuously.
// Define LCD_PREFIX_EN to prefix each row with "0x".
module lcd_hex_driver
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYCLES = 750000,
   parameter int EN_CYCLES      = 12,
   parameter int CMD_CYCLES     = 2500,
   parameter int CLEAR_CYCLES   = 82000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] line1,
   input  logic [31:0] line2,
   output logic [7:0]  LCD_DATA,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_EN,
   output logic        frame_done
);

   localparam int M1 = (POWERUP_CYCLES > EN_CYCLES) ? POWERUP_CYCLES : EN_CYCLES;
   localparam int M2 = (CMD_CYCLES > CLEAR_CYCLES) ? CMD_CYCLES : CLEAR_CYCLES;
   localparam int MAXC = (M1 > M2) ? M1 : M2;
   localparam int TW = $clog2(MAXC + 1);
   localparam logic [TW-1:0] PU_LAST = TW'(POWERUP_CYCLES - 1);
   localparam logic [3:0] ROW_LAST = 4'(ROW_LEN - 1);

   state_t        state, nxt_state;
   logic [3:0]    idx, nxt_idx;
   logic [TW-1:0] timer;
   logic [31:0]   snap1, snap2, word;
   logic          cap;
   logic          start, busy, done;
   logic [7:0]    wr_data;
   logic          wr_rs, wr_long;
   logic [2:0]    pos;
   logic [3:0]    nib;

   assign LCD_RW = 1'b0;

   // start fires for the write that follows; nxt_* names that write
   always_comb begin
      start     = 1'b0;
      nxt_state = state;
      nxt_idx   = idx;
      unique case (state)
         PWRUP: begin
            start     = (timer == PU_LAST) && !busy;
            nxt_state = INIT;
            nxt_idx   = 4'd0;
         end
         INIT: begin
            start = done;
            if (idx == 4'd3) begin
               nxt_state = ADDR1;
               nxt_idx   = 4'd0;
            end else begin
               nxt_idx = idx + 4'd1;
            end
         end
         ADDR1: begin
            start     = done;
            nxt_state = ROW1;
            nxt_idx   = 4'd0;
         end
         ROW1: begin
            start = done;
            if (idx == ROW_LAST) begin
               nxt_state = ADDR2;
               nxt_idx   = 4'd0;
            end else begin
               nxt_idx = idx + 4'd1;
            end
         end
         ADDR2: begin
            start     = done;
            nxt_state = ROW2;
            nxt_idx   = 4'd0;
         end
         ROW2: begin
            start   = done && (idx != ROW_LAST);
            nxt_idx = idx + 4'd1;
         end
         DONE: begin
            start     = !busy;
            nxt_state = ADDR1;
            nxt_idx   = 4'd0;
         end
         default: ;
      endcase
   end

   always_comb begin
      word = (nxt_state == ROW1) ? snap1 : snap2;
`ifdef LCD_PREFIX_EN
      pos = 3'(nxt_idx - 4'd2);
`else
      pos = 3'(nxt_idx);
`endif
      nib     = word[5'd28 - {pos, 2'b00} +: 4];
      wr_rs   = 1'b0;
      wr_data = 8'h00;
      unique case (nxt_state)
         INIT:  wr_data = init_cmd(nxt_idx[1:0]);
         ADDR1: wr_data = CMD_ROW1;
         ADDR2: wr_data = CMD_ROW2;
         ROW1, ROW2: begin
            wr_rs   = 1'b1;
            wr_data = hex_char(nib);
`ifdef LCD_PREFIX_EN
            if (nxt_idx == 4'd0)
               wr_data = ASC_DIGIT;
            else if (nxt_idx == 4'd1)
               wr_data = ASC_X;
`endif
         end
         default: ;
      endcase
      wr_long = !wr_rs && (wr_data == CMD_CLEAR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= PWRUP;
         idx        <= 4'd0;
         timer      <= '0;
         snap1      <= 32'd0;
         snap2      <= 32'd0;
         cap        <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         cap        <= 1'b0;
         frame_done <= 1'b0;
         // Inputs are sampled only during the 0x80 setup clock
         if (cap) begin
            snap1 <= line1;
            snap2 <= line2;
         end
         if (state == PWRUP && timer != PU_LAST)
            timer <= timer + TW'(1);
         if (state == ROW2 && done && idx == ROW_LAST) begin
            state      <= DONE;
            frame_done <= 1'b1;
         end
         if (start) begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cap   <= (nxt_state == ADDR1);
         end
      end
   end

   lcd_strobe #(
      .EN_CYCLES    (EN_CYCLES),
      .CMD_CYCLES   (CMD_CYCLES),
      .CLEAR_CYCLES (CLEAR_CYCLES),
      .TW           (TW)
   ) u_strobe (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .data      (wr_data),
      .rs        (wr_rs),
      .long_wait (wr_long),
      .busy      (busy),
      .done      (done),
      .lcd_data  (LCD_DATA),
      .lcd_rs    (LCD_RS),
      .lcd_en    (LCD_EN)
   );

endmodule

// File: tb/tb_lcd_hex_driver.sv
// Scoreboard bench for lcd_hex_driver: expected writes are queued and
// popped on each EN rising edge, with data, RS and write spacing checked.
module tb_lcd_hex_driver;

   localparam int P     = 10;
   localparam int EN    = 2;
   localparam int CMD   = 4;
   localparam int CLR   = 8;
   localparam int W     = 1 + EN + CMD;
   localparam int WC    = 1 + EN + CLR;
`ifdef LCD_PREFIX_EN
   localparam int RL = 10;
`else
   localparam int RL = 8;
`endif
   localparam int NW     = 2 * RL + 2;
   localparam int PERIOD = NW * W + 1;
   localparam int LIMIT  = 400;

   typedef struct {
      logic [7:0] data;
      logic       rs;
      int         dur;
   } wr_t;

   logic        clock;
   logic        reset;
   logic [31:0] line1, line2;
   logic [7:0]  LCD_DATA;
   logic        LCD_RS, LCD_RW, LCD_EN, frame_done;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rel;
   int   prev_t, prev_dur;
   bit   have_prev;
   wr_t  sb[$];
   int   rises[$];
   int   widths[$];
   int   hi_cnt = 0;
   logic fd_prev = 1'b0;
   string hexs;

   lcd_hex_driver #(
      .POWERUP_CYCLES (P),
      .EN_CYCLES      (EN),
      .CMD_CYCLES     (CMD),
      .CLEAR_CYCLES   (CLR)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .line1      (line1),
      .line2      (line2),
      .LCD_DATA   (LCD_DATA),
      .LCD_RS     (LCD_RS),
      .LCD_RW     (LCD_RW),
      .LCD_EN     (LCD_EN),
      .frame_done (frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (frame_done === 1'b1) begin
         hi_cnt <= hi_cnt + 1;
         if (fd_prev !== 1'b1) rises.push_back(cyc);
      end else if (fd_prev === 1'b1) begin
         widths.push_back(hi_cnt);
         hi_cnt <= 0;
      end
      fd_prev <= frame_done;
   end

   task automatic push(input logic [7:0] d, input logic r, input int du);
      wr_t e;
      e.data = d;
      e.rs   = r;
      e.dur  = du;
      sb.push_back(e);
   endtask

   task automatic push_row(input logic [31:0] a);
      logic [3:0] n;
`ifdef LCD_PREFIX_EN
      push(8'h30, 1'b1, W);
      push(8'h78, 1'b1, W);
`endif
      for (int k = 0; k < 8; k++) begin
         n = 4'(a >> (28 - 4 * k));
         push(hexs[n], 1'b1, W);
      end
   endtask

   task automatic push_frame(input logic [31:0] a, input logic [31:0] b);
      push(8'h80, 1'b0, W);
      push_row(a);
      push(8'hC0, 1'b0, W);
      push_row(b);
      sb[sb.size() - 1].dur = W + 1;
   endtask

   task automatic push_init();
      push(8'h38, 1'b0, W);
      push(8'h0C, 1'b0, W);
      push(8'h01, 1'b0, WC);
      push(8'h06, 1'b0, W);
   endtask

   task automatic wait_rise(output logic [7:0] d, output logic r,
                            output int t, output bit ok);
      int n = 0;
      ok = 1'b0;
      d  = 8'h00;
      r  = 1'b0;
      t  = 0;
      while (LCD_EN === 1'b1 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      while (LCD_EN !== 1'b1 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      if (LCD_EN === 1'b1) begin
         ok = 1'b1;
         d  = LCD_DATA;
         r  = LCD_RS;
         t  = cyc;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if (LCD_EN !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_en got=%b want=0", LCD_EN);
      end
      n_cmp++;
      if (LCD_RS !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rs got=%b want=0", LCD_RS);
      end
      n_cmp++;
      if (LCD_DATA !== 8'h00) begin
         n_bad++;
         $display("FAIL reset_data got=%h want=00", LCD_DATA);
      end
      n_cmp++;
      if (LCD_RW !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_rw got=%b want=0", LCD_RW);
      end
      n_cmp++;
      if (frame_done !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_fd got=%b want=0", frame_done);
      end
      @(posedge clock);
      #1 reset = 1'b0;
      rel = cyc;
      have_prev = 1'b0;
   endtask

   task automatic test_init();
      logic [7:0] d;
      logic r;
      int t;
      bit ok;
      wr_t e;
      push_init();
      for (int i = 0; i < 4; i++) begin
         wait_rise(d, r, t, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL init_timeout write=%0d want=%h", i, e.data);
            sb.delete();
            break;
         end
         if (d !== e.data || r !== e.rs) begin
            n_bad++;
            $display("FAIL init_write%0d got=%h/%b want=%h/%b", i, d, r, e.data, e.rs);
         end
         if (i == 0) begin
            n_cmp++;
            if (t - rel != P + 1) begin
               n_bad++;
               $display("FAIL init_first_en got=%0d want=%0d", t - rel, P + 1);
            end
         end
         if (have_prev) begin
            n_cmp++;
            if (t - prev_t != prev_dur) begin
               n_bad++;
               $display("FAIL init_gap%0d got=%0d want=%0d", i, t - prev_t, prev_dur);
            end
         end
         prev_t    = t;
         prev_dur  = e.dur;
         have_prev = 1'b1;
      end
   endtask

   task automatic test_rows();
      logic [7:0] d;
      logic r;
      int t;
      bit ok;
      wr_t e;
      push_frame(line1, line2);
      for (int i = 0; i < NW; i++) begin
         wait_rise(d, r, t, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL rows_timeout write=%0d want=%h", i, e.data);
            sb.delete();
            break;
         end
         if (d !== e.data || r !== e.rs) begin
            n_bad++;
            $display("FAIL rows_write%0d got=%h/%b want=%h/%b", i, d, r, e.data, e.rs);
         end
         if (have_prev) begin
            n_cmp++;
            if (t - prev_t != prev_dur) begin
               n_bad++;
               $display("FAIL rows_gap%0d got=%0d want=%0d", i, t - prev_t, prev_dur);
            end
         end
         prev_t    = t;
         prev_dur  = e.dur;
         have_prev = 1'b1;
      end
   endtask

   task automatic test_snapshot();
      logic [7:0] d;
      logic r;
      int t;
      bit ok;
      wr_t e;
      logic [31:0] fresh;
      fresh = 32'h9F0E_5A61;
      push_frame(line1, line2);
      push_frame(fresh, line2);
      for (int i = 0; i < 2 * NW; i++) begin
         wait_rise(d, r, t, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL snap_timeout write=%0d want=%h", i, e.data);
            sb.delete();
            break;
         end
         if (d !== e.data || r !== e.rs) begin
            n_bad++;
            $display("FAIL snap_write%0d got=%h/%b want=%h/%b", i, d, r, e.data, e.rs);
         end
         if (have_prev) begin
            n_cmp++;
            if (t - prev_t != prev_dur) begin
               n_bad++;
               $display("FAIL snap_gap%0d got=%0d want=%0d", i, t - prev_t, prev_dur);
            end
         end
         prev_t    = t;
         prev_dur  = e.dur;
         have_prev = 1'b1;
         if (i == 3) line1 = fresh;
      end
   endtask

   task automatic test_frame_done();
      int n = 0;
      while (rises.size() < 3 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      @(negedge clock);
      @(negedge clock);
      n_cmp++;
      if (rises.size() < 3 || widths.size() < 3) begin
         n_bad++;
         $display("FAIL fd_count got=%0d want=3", rises.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (widths[k] != 1) begin
               n_bad++;
               $display("FAIL fd_width%0d got=%0d want=1", k, widths[k]);
            end
         end
         for (int k = 1; k < 3; k++) begin
            n_cmp++;
            if (rises[k] - rises[k-1] != PERIOD) begin
               n_bad++;
               $display("FAIL fd_period%0d got=%0d want=%0d", k, rises[k] - rises[k-1], PERIOD);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      logic r;
      int t;
      bit ok;
      wr_t e;
      int n = 0;
      while (LCD_EN !== 1'b1 && n < LIMIT) begin
         @(negedge clock);
         n++;
      end
      n_cmp++;
      if (LCD_EN !== 1'b1) begin
         n_bad++;
         $display("FAIL rmid_no_en got=%b want=1", LCD_EN);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (LCD_EN !== 1'b0 || LCD_DATA !== 8'h00 || LCD_RS !== 1'b0 || LCD_RW !== 1'b0) begin
         n_bad++;
         $display("FAIL rmid_async got=%b/%h/%b/%b want=0/00/0/0", LCD_EN, LCD_DATA, LCD_RS, LCD_RW);
      end
      repeat (3) @(negedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      rel = cyc;
      have_prev = 1'b0;
      push_init();
      for (int i = 0; i < 4; i++) begin
         wait_rise(d, r, t, ok);
         e = sb.pop_front();
         n_cmp++;
         if (!ok) begin
            n_bad++;
            $display("FAIL rmid_timeout write=%0d want=%h", i, e.data);
            sb.delete();
            break;
         end
         if (d !== e.data || r !== e.rs) begin
            n_bad++;
            $display("FAIL rmid_write%0d got=%h/%b want=%h/%b", i, d, r, e.data, e.rs);
         end
         if (i == 0) begin
            n_cmp++;
            if (t - rel != P + 1) begin
               n_bad++;
               $display("FAIL rmid_first_en got=%0d want=%0d", t - rel, P + 1);
            end
         end
         if (have_prev) begin
            n_cmp++;
            if (t - prev_t != prev_dur) begin
               n_bad++;
               $display("FAIL rmid_gap%0d got=%0d want=%0d", i, t - prev_t, prev_dur);
            end
         end
         prev_t    = t;
         prev_dur  = e.dur;
         have_prev = 1'b1;
      end
   endtask

   initial begin
      hexs  = "0123456789ABCDEF";
      reset = 1'b1;
      line1 = 32'h12AB_34CF;
      line2 = 32'hDEAD_BEEF;
      test_reset();
      test_init();
      test_rows();
      test_snapshot();
      test_frame_done();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
